// File: rtl/serial_word_capture.sv
// Reassembles WIDTH-bit words from a qualified serial stream (LS395A carry output),
// with frame-start sync, truncated-frame detection and a valid/ack handoff with overrun.
module serial_word_capture #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       iClk,
    input  logic                       iClr_n,
    input  logic                       iSER,
    input  logic                       iShift,
    input  logic                       iSync,
    input  logic                       iAck,
    input  logic                       iClrErr,
    output logic [WIDTH-1:0]           oData,
    output logic                       oValid,
    output logic [$clog2(WIDTH+1)-1:0] oBitCnt,
    output logic                       oBusy,
    output logic                       oOverrun,
    output logic                       oFrameErr
);

    localparam int CNT_W = $clog2(WIDTH+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic               valid_q,     valid_d;
    logic               overrun_q,   overrun_d;
    logic               frame_err_q, frame_err_d;

    logic [WIDTH-1:0]   appended;
    logic [WIDTH-1:0]   first_bit;
    logic               complete;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        complete    = 1'b0;

        // The first bit of a frame sits where subsequent shifts will carry it to its final slot.
        if (MSB_FIRST) begin
            appended  = {shreg_q[WIDTH-2:0], iSER};
            first_bit = {{(WIDTH-1){1'b0}}, iSER};
        end else begin
            appended  = {iSER, shreg_q[WIDTH-1:1]};
            first_bit = {iSER, {(WIDTH-1){1'b0}}};
        end

        if (iClrErr) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        if (iShift) begin
            unique case (state_q)
                IDLE: begin
                    if (iSync) begin
                        shreg_d = first_bit;
                        cnt_d   = CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (iSync) begin
                        // Completion always returns to IDLE, so a sync seen here truncates a frame.
                        frame_err_d = 1'b1;
                        shreg_d     = first_bit;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        complete = 1'b1;
                        shreg_d  = appended;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        shreg_d = appended;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (complete) begin
            if (!valid_q || iAck) begin
                data_d  = appended;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (iAck && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Falling edge matches the upstream LS395A, so each bit is taken before it shifts away.
    always_ff @(negedge iClk or negedge iClr_n) begin
        if (!iClr_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign oData     = data_q;
    assign oValid    = valid_q;
    assign oBitCnt   = cnt_q;
    assign oBusy     = (state_q == SHIFT);
    assign oOverrun  = overrun_q;
    assign oFrameErr = frame_err_q;

endmodule

// File: tb/tb_serial_word_capture.sv
// Self-checking bench: MSB-first and LSB-first instances share one stimulus stream;
// expected words are queued when their last bit is driven and compared on completion.
module tb_serial_word_capture;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH+1);

    logic             iClk;
    logic             iClr_n;
    logic             iSER;
    logic             iShift;
    logic             iSync;
    logic             iAck;
    logic             iClrErr;

    logic [WIDTH-1:0] m_data,    l_data;
    logic             m_valid,   l_valid;
    logic [CNT_W-1:0] m_cnt,     l_cnt;
    logic             m_busy,    l_busy;
    logic             m_ovr,     l_ovr;
    logic             m_ferr,    l_ferr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_msb_q[$];
    logic [WIDTH-1:0] exp_lsb_q[$];

    serial_word_capture #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut (
        .iClk(iClk), .iClr_n(iClr_n), .iSER(iSER), .iShift(iShift), .iSync(iSync),
        .iAck(iAck), .iClrErr(iClrErr), .oData(m_data), .oValid(m_valid),
        .oBitCnt(m_cnt), .oBusy(m_busy), .oOverrun(m_ovr), .oFrameErr(m_ferr)
    );

    serial_word_capture #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
        .iClk(iClk), .iClr_n(iClr_n), .iSER(iSER), .iShift(iShift), .iSync(iSync),
        .iAck(iAck), .iClrErr(iClrErr), .oData(l_data), .oValid(l_valid),
        .oBitCnt(l_cnt), .oBusy(l_busy), .oOverrun(l_ovr), .oFrameErr(l_ferr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
        return r;
    endfunction

    // Inputs change on the rising edge; outputs are read 1 ns after the active falling edge.
    task automatic step(input logic ser, input logic shift, input logic sync,
                        input logic ack, input logic clrerr);
        @(posedge iClk);
        iSER    = ser;
        iShift  = shift;
        iSync   = sync;
        iAck    = ack;
        iClrErr = clrerr;
        @(negedge iClk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'd0, m_data}, 32'h0);
        check({tag, "_valid"}, {31'd0, m_valid}, 32'h0);
        check({tag, "_cnt"},   {28'd0, m_cnt}, 32'h0);
        check({tag, "_busy"},  {31'd0, m_busy}, 32'h0);
        check({tag, "_ovr"},   {31'd0, m_ovr}, 32'h0);
        check({tag, "_ferr"},  {31'd0, m_ferr}, 32'h0);
        check({tag, "_ldata"}, {24'd0, l_data}, 32'h0);
        check({tag, "_lvalid"}, {31'd0, l_valid}, 32'h0);
    endtask

    // Sends one frame MSB of `word` first; optional gaps insert iShift=0 edges with noisy ser/sync.
    task automatic send_frame(input logic [WIDTH-1:0] word, input bit ack_last,
                              input bit deliver, input bit clr_first, input bit gaps);
        logic [WIDTH-1:0] w;
        logic b;
        w = word;
        for (int i = 0; i < WIDTH; i++) begin
            b = w[WIDTH-1-i];
            if (i == WIDTH-1 && deliver) begin
                exp_msb_q.push_back(word);
                exp_lsb_q.push_back(bit_reverse(word));
            end
            step(b, 1'b1, (i == 0), (i == WIDTH-1) && ack_last, (i == 0) && clr_first);
            check($sformatf("bitcnt_%0d", i), {28'd0, m_cnt},
                  (i == WIDTH-1) ? 32'd0 : 32'(i + 1));
            if (gaps && i != WIDTH-1) begin
                step(~b, 1'b0, 1'b1, 1'b0, 1'b0);
                check($sformatf("gapcnt_%0d", i), {28'd0, m_cnt}, 32'(i + 1));
            end
        end
        if (deliver) begin
            if (exp_msb_q.size() == 0 || exp_lsb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("word_msb", {24'd0, m_data}, {24'd0, exp_msb_q.pop_front()});
                check("word_lsb", {24'd0, l_data}, {24'd0, exp_lsb_q.pop_front()});
                check("valid_on_done", {31'd0, m_valid}, 32'd1);
            end
        end
        check("busy_after_done", {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        iClr_n = 1'b0; iSER = 1'b0; iShift = 1'b0; iSync = 1'b0; iAck = 1'b0; iClrErr = 1'b0;
        repeat (3) @(negedge iClk);
        #1;
        check_reset_outputs("reset");
        @(posedge iClk);
        iClr_n = 1'b1;

        // Unsynchronised bits in IDLE are ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_cnt",   {28'd0, m_cnt}, 32'd0);
        check("idle_valid", {31'd0, m_valid}, 32'd0);
        check("idle_busy",  {31'd0, m_busy}, 32'd0);

        // Basic frame: 1,0,1,1,0,0,1,0 -> 0xB2 / 0x4D.
        send_frame(8'hB2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2_abs_msb", {24'd0, m_data}, 32'hB2);
        check("b2_abs_lsb", {24'd0, l_data}, 32'h4D);
        check("b2_ovr",     {31'd0, m_ovr}, 32'd0);
        check("b2_ferr",    {31'd0, m_ferr}, 32'd0);

        // Unacknowledged: second word is dropped.
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_data",  {24'd0, m_data}, 32'hB2);
        check("ovr_valid", {31'd0, m_valid}, 32'd1);
        check("ovr_flag",  {31'd0, m_ovr}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr",       {31'd0, m_ovr}, 32'd0);
        check("ovr_clr_valid", {31'd0, m_valid}, 32'd1);

        // Ack on the completion edge lets the new word through.
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        check("ackdone_data", {24'd0, m_data}, 32'h5A);
        check("ackdone_ovr",  {31'd0, m_ovr}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ack_valid", {31'd0, m_valid}, 32'd0);
        check("ack_hold",  {24'd0, m_data}, 32'h5A);

        // Truncated frame; the restarting sync edge also carries iClrErr (set must win).
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("part_cnt",  {28'd0, m_cnt}, 32'd3);
        check("part_busy", {31'd0, m_busy}, 32'd1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ferr_set",  {31'd0, m_ferr}, 32'd1);
        check("ferr_lset", {31'd0, l_ferr}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ferr_clr",   {31'd0, m_ferr}, 32'd0);
        check("ferr_valid", {31'd0, m_valid}, 32'd0);

        // iShift=0 gaps inside a frame.
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back frames: sync right after completion is legal.
        send_frame(8'h96, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h69, 1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_ferr", {31'd0, m_ferr}, 32'd0);
        check("b2b_ovr",  {31'd0, m_ovr}, 32'd0);

        // Reset mid-frame at count 5 clears everything asynchronously.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_cnt", {28'd0, m_cnt}, 32'd5);
        #2;
        iClr_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge iClk);
        iClr_n = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_data", {24'd0, m_data}, 32'h3C);
        check("post_rst_ferr", {31'd0, m_ferr}, 32'd0);

        check("sb_empty", 32'(exp_msb_q.size() + exp_lsb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_capture.md
# serial_word_capture

Downstream stage for the 74LS395A shift-register model. It samples the serial stream taken from the register's carry output (Q3, MSB first) and reassembles WIDTH-bit words. It also detects frame start and truncated frames, and hands completed words to the consumer over a valid/ack handshake with overrun detection. It clocks on the same falling edge as the shift register it monitors, so each bit is captured just before that register shifts it out.

## Interface
- WIDTH, 8: bits per word; legal range 2..16 (two cascaded LS395A give 8).
- MSB_FIRST, 1: 1 = first received bit lands in oData[WIDTH-1]; 0 = first bit lands in oData[0].
- iClk  in  1  clock; all state updates on negedge, matching the LS395A model.
- iClr_n  in  1  reset; asynchronous, active-low.
- iSER  in  1  serial data; connect to the upstream register's oCarry.
- iShift  in  1  bit qualifier; 1 = a bit is present this edge (upstream shift cycle, LDSH low).
- iSync  in  1  frame start; only meaningful with iShift=1. Marks the sampled bit as bit 0 of a new word.
- iAck  in  1  consumer has taken oData.
- iClrErr  in  1  clears the sticky error flags.
- oData  out  WIDTH  last completed word; held until replaced.
- oValid  out  1  oData holds an unacknowledged word.
- oBitCnt  out  $clog2(WIDTH+1)  bits collected in the current frame.
- oBusy  out  1  frame in progress (state SHIFT).
- oOverrun  out  1  sticky: a completed word was dropped.
- oFrameErr  out  1  sticky: a frame was truncated by a new iSync.

## Operation
- Reset (iClr_n=0, asynchronous) forces:
  - state IDLE, shift register 0, oBitCnt 0;
  - oData 0, oValid 0, oOverrun 0, oFrameErr 0, oBusy 0.
- States: IDLE, SHIFT.
- Edges with iShift=0: no state, count or shifter change. Handshake and error-clear logic still run.
- IDLE
  - iShift=1, iSync=0: bit ignored.
  - iShift=1, iSync=1: load the bit as bit 0, set count to 1, go to SHIFT.
- SHIFT
  - iShift=1, iSync=0: append the bit and increment the count.
  - iShift=1, iSync=1 with count < WIDTH: set oFrameErr, discard the partial word, restart with this bit as bit 0 (count 1), stay in SHIFT.
- Bit insertion:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
- Completion: occurs on the edge that appends the WIDTH-th bit.
  - The assembled word (including that bit) is delivered, count returns to 0, state returns to IDLE.
  - WIDTH=2 with iSync on the first bit: completion takes exactly two qualified edges.
- Delivery:
  - If oValid=0, or oValid=1 with iAck=1 on the same edge: oData gets the word and oValid is 1.
  - Otherwise: the word is dropped, oOverrun is set, and oData/oValid are unchanged.
- Handshake:
  - iAck=1 with oValid=1 and no delivery on the same edge: oValid goes 0; oData is retained.
  - iAck with oValid=0 is ignored.
- Errors: iClrErr=1 clears both flags. If a set condition occurs on the same edge, set wins.
- A new frame may begin on the edge immediately after completion; iSync there is legal and is not an error.

## Timing
- All registered outputs change only on negedge iClk, or asynchronously on reset.
- Latency: oValid rises on the same falling edge that samples the last bit. Word-to-word minimum spacing is WIDTH qualified edges.
- oBusy is combinational from state (state == SHIFT); no other combinational paths.
- iSER, iShift, iSync, iAck and iClrErr must be stable around the falling edge. They are sampled against the pre-edge value of upstream oCarry.
- Reset mid-frame discards the partial word with no error flag. Deasserting reset restarts in IDLE on the next edge.

## Test plan
- WIDTH=8, MSB_FIRST=1: iSync on first bit, serial bits 1,0,1,1,0,0,1,0 → oData=0xB2 and oValid=1 on the 8th edge. oBitCnt steps 1..7 then 0. No flags.
- Same stream with MSB_FIRST=0 → oData=0x4D.
- Word 0xB2 left unacknowledged, second frame 0x5A completes → oData stays 0xB2, oOverrun=1. Repeat with iAck=1 on the completion edge → oData=0x5A, oValid=1, no overrun.
- iSync after 3 bits of a frame, then 8 bits 0xFF → oFrameErr=1, oData=0xFF. Assert iClrErr → flag 0.
- Bits with iShift=1, iSync=0 in IDLE → no count change and no oValid. iShift=0 gaps inside a frame → word assembles correctly.
- iClr_n pulsed low mid-frame at count 5 → all outputs 0 immediately. The next full frame with 0x3C → oData=0x3C.
